// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// per-stage shadow record kept for hazard detection, and a source-match helper.
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } stage_shadow_t;

    localparam stage_shadow_t SHADOW_EMPTY = '0;

    function automatic logic src_hit(input logic used,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode/redirect/status inputs and stall/flush/multicycle outputs of the
// pipeline sequencer, bundled so the pipeline top can hand them over as one port.
interface pipeline_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              id_is_mc;
    logic              ex_redirect;
    logic              mc_done;
    logic              mem_busy;

    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              stall_mem;
    logic              flush_id;
    logic              flush_ex;
    logic              bubble_mem;
    logic              mc_start;
    logic              mc_timeout;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_load, id_is_mc, ex_redirect, mc_done, mem_busy,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
               bubble_mem, mc_start, mc_timeout, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_load, id_is_mc, ex_redirect, mc_done, mem_busy,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
               bubble_mem, mc_start, mc_timeout, stall_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard compare of the ID-stage sources against the EX-stage shadow.
// Purely combinational so a forwarding unit can reuse it.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  stage_shadow_t     ex_q,
    output logic              hazard
);

    logic ex_load_dst;

    // x0 is hardwired zero, so a load targeting it never produces a dependency.
    assign ex_load_dst = ex_q.valid && ex_q.is_load && ex_q.reg_write && (ex_q.rd != '0);

    assign hazard = id_valid && ex_load_dst &&
                    (src_hit(id_rs1_used, id_rs1, ex_q.rd) ||
                     src_hit(id_rs2_used, id_rs2, ex_q.rd));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; shadows EX/MEM occupants and
// runs the multicycle-unit start/wait handshake.
//
//   state   | meaning
//   RUN     | normal issue; load-use and redirect handling
//   MC_WAIT | mul/div op parked in EX until an accepted mc_done
module pipeline_ctrl #(
    parameter int REG_AW        = 5,
    parameter int MC_MAX_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipeline_ctrl_if.slave    bus
);
    import pipe_ctrl_pkg::*;

    localparam int MC_W = $clog2(MC_MAX_CYCLES + 1);
    localparam logic [MC_W-1:0] MC_SAT = MC_W'(MC_MAX_CYCLES);

    ctrl_state_t      state_q, state_nxt;
    stage_shadow_t    ex_q, ex_nxt, mem_q, mem_nxt, id_shadow;
    logic             mc_start_q, mc_start_nxt;
    logic             mc_timeout_q;
    logic [MC_W-1:0]  mc_cnt_q;
    logic             mc_count;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             hazard;
    logic             mc_accept;
    logic             c_stall_if, c_stall_id, c_stall_ex, c_stall_mem;
    logic             c_flush_id, c_flush_ex, c_bubble_mem;

    load_use_detect u_load_use (
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_rs1_used (bus.id_rs1_used),
        .id_rs2_used (bus.id_rs2_used),
        .ex_q        (ex_q),
        .hazard      (hazard)
    );

    assign id_shadow = '{valid:     bus.id_valid,
                         rd:        bus.id_rd,
                         reg_write: bus.id_reg_write,
                         is_load:   bus.id_is_load};

    // The start pulse and mc_done can coincide; that mc_done belongs to no op of ours.
    assign mc_accept = bus.mc_done && !mc_start_q;

    always_comb begin
        state_nxt    = state_q;
        ex_nxt       = ex_q;
        mem_nxt      = mem_q;
        mc_start_nxt = 1'b0;
        mc_count     = 1'b0;
        c_stall_if   = 1'b0;
        c_stall_id   = 1'b0;
        c_stall_ex   = 1'b0;
        c_stall_mem  = 1'b0;
        c_flush_id   = 1'b0;
        c_flush_ex   = 1'b0;
        c_bubble_mem = 1'b0;

        if (bus.mem_busy) begin
            c_stall_if  = 1'b1;
            c_stall_id  = 1'b1;
            c_stall_ex  = 1'b1;
            c_stall_mem = 1'b1;
        end else if (state_q == MC_WAIT && !mc_accept) begin
            c_stall_if   = 1'b1;
            c_stall_id   = 1'b1;
            c_stall_ex   = 1'b1;
            c_bubble_mem = 1'b1;
            mem_nxt      = SHADOW_EMPTY;
            mc_count     = 1'b1;
        end else begin
            if (state_q == MC_WAIT) begin
                mc_count  = 1'b1;
                state_nxt = RUN;
            end
            // EX holds the mc op while waiting, so a redirect then is spurious.
            if (bus.ex_redirect && state_q == RUN) begin
                c_flush_id = 1'b1;
                c_flush_ex = 1'b1;
            end else if (hazard) begin
                c_stall_if = 1'b1;
                c_stall_id = 1'b1;
                c_flush_ex = 1'b1;
            end else if (state_q == RUN && bus.id_valid && bus.id_is_mc) begin
                state_nxt    = MC_WAIT;
                mc_start_nxt = 1'b1;
            end
            ex_nxt  = c_flush_ex ? SHADOW_EMPTY : id_shadow;
            mem_nxt = ex_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            ex_q         <= SHADOW_EMPTY;
            mem_q        <= SHADOW_EMPTY;
            mc_start_q   <= 1'b0;
            mc_timeout_q <= 1'b0;
            mc_cnt_q     <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q    <= state_nxt;
            ex_q       <= ex_nxt;
            mem_q      <= mem_nxt;
            mc_start_q <= mc_start_nxt;
            if (mc_start_nxt) begin
                mc_cnt_q <= '0;
            end else if (mc_count && mc_cnt_q != MC_SAT) begin
                mc_cnt_q <= mc_cnt_q + 1'b1;
            end
            if (mc_count && (int'(mc_cnt_q) + 1 >= MC_MAX_CYCLES)) begin
                mc_timeout_q <= 1'b1;
            end
            if (c_stall_if && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    // Inputs may be toggling while reset is held; keep every control quiet.
    assign bus.stall_if   = rst_n & c_stall_if;
    assign bus.stall_id   = rst_n & c_stall_id;
    assign bus.stall_ex   = rst_n & c_stall_ex;
    assign bus.stall_mem  = rst_n & c_stall_mem;
    assign bus.flush_id   = rst_n & c_flush_id;
    assign bus.flush_ex   = rst_n & c_flush_ex;
    assign bus.bubble_mem = rst_n & c_bubble_mem;
    assign bus.mc_start   = mc_start_q;
    assign bus.mc_timeout = mc_timeout_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a cycle-level
// reference model built from the stall/flush priority rules.
module tb_pipeline_ctrl;

    localparam int REG_AW = 5;
    localparam int MC_MAX = 8;
    localparam int CNT_W  = 6;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.REG_AW(REG_AW), .MC_MAX_CYCLES(MC_MAX), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: what sits in EX, whether an mc op is outstanding, and the counters.
    bit              m_ex_v, m_ex_rw, m_ex_ld;
    int              m_ex_rd;
    bit              m_wait, m_start, m_tmo;
    int              m_wait_cycles, m_scnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex_v = 0; m_ex_rw = 0; m_ex_ld = 0; m_ex_rd = 0;
        m_wait = 0; m_start = 0; m_tmo = 0; m_wait_cycles = 0; m_scnt = 0;
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit ld, input bit mc,
                         input bit redir, input bit done, input bit busy);
        bus.id_valid     = v;
        bus.id_rs1       = REG_AW'(rs1);
        bus.id_rs1_used  = u1;
        bus.id_rs2       = REG_AW'(rs2);
        bus.id_rs2_used  = u2;
        bus.id_rd        = REG_AW'(rd);
        bus.id_reg_write = rw;
        bus.id_is_load   = ld;
        bus.id_is_mc     = mc;
        bus.ex_redirect  = redir;
        bus.mc_done      = done;
        bus.mem_busy     = busy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic bit reads_reg(input int r);
        return (bus.id_rs1_used && int'(bus.id_rs1) == r) ||
               (bus.id_rs2_used && int'(bus.id_rs2) == r);
    endfunction

    // One clock: compare combinational and registered outputs, then step the model.
    task automatic cycle();
        int cls;
        bit hz;
        bit new_mc;
        logic [6:0] exp_ctl, obs_ctl;
        #1;
        hz = bus.id_valid && m_ex_v && m_ex_ld && m_ex_rw && m_ex_rd != 0 && reads_reg(m_ex_rd);
        if (bus.mem_busy)                          cls = 1;
        else if (m_wait && !(bus.mc_done && !m_start)) cls = 2;
        else if (!m_wait && bus.ex_redirect)       cls = 3;
        else if (hz)                               cls = 4;
        else                                       cls = 5;
        // order: stall_if stall_id stall_ex stall_mem flush_id flush_ex bubble_mem
        case (cls)
            1:       exp_ctl = 7'b1111000;
            2:       exp_ctl = 7'b1110001;
            3:       exp_ctl = 7'b0000110;
            4:       exp_ctl = 7'b1100010;
            default: exp_ctl = 7'b0000000;
        endcase
        obs_ctl = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                   bus.flush_id, bus.flush_ex, bus.bubble_mem};
        chk("ctl", 64'(obs_ctl), 64'(exp_ctl));
        chk("mc_start", 64'(bus.mc_start), 64'(m_start));
        chk("mc_timeout", 64'(bus.mc_timeout), 64'(m_tmo));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_scnt));

        if (exp_ctl[6] && m_scnt < CNT_SAT) m_scnt++;
        new_mc = 0;
        if (cls != 1 && m_wait) begin
            m_wait_cycles++;
            if (m_wait_cycles >= MC_MAX) m_tmo = 1;
        end
        if (cls >= 3) begin
            if (m_wait) m_wait = 0;
            else if (cls == 5 && bus.id_valid && bus.id_is_mc) new_mc = 1;
            if (cls == 5) begin
                m_ex_v = bus.id_valid; m_ex_rd = int'(bus.id_rd);
                m_ex_rw = bus.id_reg_write; m_ex_ld = bus.id_is_load;
            end else begin
                m_ex_v = 0; m_ex_rd = 0; m_ex_rw = 0; m_ex_ld = 0;
            end
        end
        if (new_mc) begin
            m_wait = 1;
            m_wait_cycles = 0;
        end
        m_start = new_mc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held while redirect/busy are asserted: every control must read 0.
        rst_n = 1'b0;
        idle();
        bus.mem_busy = 1'b1;
        bus.ex_redirect = 1'b1;
        model_reset();
        #3;
        chk("rst_stall_if", 64'(bus.stall_if), 64'(0));
        chk("rst_stall_mem", 64'(bus.stall_mem), 64'(0));
        chk("rst_flush_id", 64'(bus.flush_id), 64'(0));
        chk("rst_mc_start", 64'(bus.mc_start), 64'(0));
        chk("rst_mc_timeout", 64'(bus.mc_timeout), 64'(0));
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load x5 then a consumer of x5: one stall cycle.
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0); cycle();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
        #1 chk("lu_stall_if", 64'(bus.stall_if), 64'(1));
        chk("lu_flush_ex", 64'(bus.flush_ex), 64'(1));
        cycle();
        #1 chk("lu_release", 64'(bus.stall_if), 64'(0));
        cycle();
        chk("lu_stall_cnt", 64'(bus.stall_cnt), 64'(1));

        // Load x0 then consumer of x0: no stall.
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
        drive(1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0);
        #1 chk("x0_no_stall", 64'(bus.stall_if), 64'(0));
        cycle();

        // Redirect overrides a load-use hazard.
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0); cycle();
        drive(1, 5, 1, 0, 0, 8, 1, 0, 0, 1, 0, 0);
        #1 chk("redir_flush_id", 64'(bus.flush_id), 64'(1));
        chk("redir_no_stall", 64'(bus.stall_if), 64'(0));
        cycle();

        // mc op; mc_done coinciding with mc_start ignored; accepted on 4th wait cycle.
        drive(1, 1, 1, 2, 1, 9, 1, 0, 1, 0, 0, 0); cycle();
        drive(1, 3, 1, 0, 0, 10, 1, 0, 0, 0, 1, 0);
        #1 chk("mc_start_c1", 64'(bus.mc_start), 64'(1));
        chk("mc_bubble_c1", 64'(bus.bubble_mem), 64'(1));
        cycle();
        bus.mc_done = 1'b0;
        cycle();
        #1 chk("mc_start_c3", 64'(bus.mc_start), 64'(0));
        chk("mc_stall_c3", 64'(bus.stall_if), 64'(1));
        cycle();
        bus.mc_done = 1'b1;
        #1 chk("mc_release_c4", 64'(bus.stall_if), 64'(0));
        cycle();
        idle(); cycle();

        // mc op: 2 wait cycles, 3 frozen by mem_busy, then wait out the timeout.
        drive(1, 1, 1, 0, 0, 11, 1, 0, 1, 0, 0, 0); cycle();
        idle();
        repeat (2) cycle();
        bus.mem_busy = 1'b1;
        #1 chk("busy_stall_mem", 64'(bus.stall_mem), 64'(1));
        chk("busy_no_bubble", 64'(bus.bubble_mem), 64'(0));
        repeat (3) cycle();
        bus.mem_busy = 1'b0;
        repeat (5) cycle();
        chk("tmo_not_yet", 64'(bus.mc_timeout), 64'(0));
        cycle();
        chk("tmo_set", 64'(bus.mc_timeout), 64'(1));
        repeat (2) cycle();

        // Asynchronous reset mid-wait, with a stale mc_done after it.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_stall_if", 64'(bus.stall_if), 64'(0));
        chk("rst_mid_timeout", 64'(bus.mc_timeout), 64'(0));
        chk("rst_mid_stall_cnt", 64'(bus.stall_cnt), 64'(0));
        chk("rst_mid_mc_start", 64'(bus.mc_start), 64'(0));
        model_reset();
        bus.mc_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 2, 1, 0, 0, 3, 1, 0, 0, 0, 1, 0);
        cycle();
        idle(); cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(9) != 0),
                  int'($urandom_range(3)), ($urandom_range(1) != 0),
                  int'($urandom_range(3)), ($urandom_range(1) != 0),
                  int'($urandom_range(3)), ($urandom_range(3) != 0),
                  ($urandom_range(2) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(7) == 0),
                  m_wait ? ($urandom_range(4) == 0) : ($urandom_range(19) == 0),
                  ($urandom_range(5) == 0));
            cycle();
        end

        // Long freeze drives stall_cnt into saturation.
        idle();
        bus.mem_busy = 1'b1;
        repeat (CNT_SAT + 6) cycle();
        chk("stall_cnt_sat", 64'(bus.stall_cnt), 64'(CNT_SAT));
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
